axil2wb_bridge: RTL and testbench
=================================

# axil2wb_bridge

AXI4-Lite slave to Wishbone classic master bridge that feeds Wishbone peripheral cores (AES and siblings) from the SoC AXI4-Lite interconnect. Each AXI transaction is converted into exactly one single-beat Wishbone cycle, and the Wishbone termination is converted back into an AXI response. Wishbone clock and reset are the bridge's own `clk_i`/`rst_ni`; the bridge has no separate Wishbone clock or reset outputs.

## Interface
- `ADDR_WIDTH`, default 32: AXI and Wishbone byte address width.
- `DATA_WIDTH`, default 32: data width. Only 32 is supported; `wb_sel_o` is 4 bits.
- `TIMEOUT_CYCLES`, default 255: number of Wishbone wait cycles before the bridge aborts. Used only with `AXIL2WB_TIMEOUT_EN`.
- `clk_i  in  1`: clock.
- `rst_ni  in  1`: reset, asynchronous, active-low.
- `slave  AXI_LITE.Slave  -`: AXI4-Lite slave interface (AW, W, B, AR, R channels).
- `wb_adr_o  out  ADDR_WIDTH`: Wishbone address, byte address passed through unchanged.
- `wb_dat_o  out  DATA_WIDTH`: write data.
- `wb_sel_o  out  4`: byte selects.
- `wb_we_o  out  1`: write enable.
- `wb_cyc_o  out  1`: cycle.
- `wb_stb_o  out  1`: strobe.
- `wb_dat_i  in  DATA_WIDTH`: read data.
- `wb_ack_i  in  1`: acknowledge.
- `wb_err_i  in  1`: error termination.

## Operation
- **Holding registers.** AW, W and AR each have a one-entry holding register.
  - `aw_ready = !aw_held`, `w_ready = !w_held`, `ar_ready = !ar_held`.
  - AW and W are accepted independently, in either order or in the same cycle.
- **FSM states:** IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
- **IDLE, write pending:** if `aw_held && w_held`, go to WB_WR.
- **IDLE, read pending:** if `ar_held`, go to WB_RD.
- **IDLE, both pending:** round-robin using a `last_was_write` flag; reset value 0, so the write goes first.
- **WB_WR:**
  - Drive `cyc=stb=we=1`, `adr=awaddr`, `dat=wdata`, `sel=wstrb`.
  - On `ack` or `err`: clear `aw_held`/`w_held`, go to B_RESP.
  - `bresp`: OKAY (2'b00) on `ack`, SLVERR (2'b10) on `err`.
- **WB_RD:**
  - Drive `cyc=stb=1`, `we=0`, `adr=araddr`, `sel=4'hF`.
  - On `ack`: latch `wb_dat_i` into `rdata`, `rresp=OKAY`.
  - On `err`: `rdata=0`, `rresp=SLVERR`.
  - On either: clear `ar_held`, go to R_RESP.
- **Simultaneous ack and err:** `err` wins.
- **B_RESP:** `b_valid=1`, held until `b_ready`, then go to IDLE.
- **R_RESP:** `r_valid=1`, held until `r_ready`, then go to IDLE.
- **Concurrency:** exactly one Wishbone cycle is outstanding at a time. New AXI addresses/data may be accepted into free holding registers during any state.
- **Reset:** assertion mid-transaction immediately clears all state, holding registers, `wb_cyc_o`/`wb_stb_o`, `b_valid` and `r_valid`. The in-flight transaction is lost.
- **Reset values:** all outputs 0, all ready outputs 0, state IDLE.

## Timing
- All outputs are registered. No combinational path from AXI inputs to Wishbone outputs.
- The `*_ready` signals rise one cycle after reset deassertion.
- **Write latency:**
  - Handshake completes at edge E0; `cyc`/`stb` are high after E1.
  - Ack sampled at edge En (n≥2); `cyc`/`stb` low and `b_valid` high after En.
  - Zero-wait slave: `b_valid` follows the last AW/W handshake by 2 cycles.
- **Read latency:** identical; `r_valid` follows the AR handshake by 2 cycles minimum.
- `cyc`/`stb` deassert on the edge that samples `ack`/`err`. Back-to-back Wishbone cycles are separated by at least 2 cycles (response state plus IDLE).
- `ack`/`err` are ignored outside WB_WR/WB_RD.

## Configuration
- **Macro:** `AXIL2WB_TIMEOUT_EN`.
- **Defined:**
  - An 8-to-16-bit wait counter clears on entry to WB_WR/WB_RD and increments each cycle without `ack`/`err`.
  - When it reaches `TIMEOUT_CYCLES`, the bridge drops `cyc`/`stb` and terminates the transaction as SLVERR (`rdata=0` for reads).
  - A late `ack` after an abort is ignored.
- **Undefined:** no counter; the bridge waits indefinitely for `ack`/`err`.

## Structure
- **Package `axil2wb_pkg`:** state enum `axil2wb_state_e`, response constants `RESP_OKAY=2'b00` and `RESP_SLVERR=2'b10`, and the read-select constant `SEL_ALL=4'hF`.
- Single module; no sub-module is warranted.

## Test plan
- **Zero-wait write.** Write addr 0x10, data 0xCAFEBABE, strb 0xF, AW and W in the same cycle, slave acks immediately. Expect one Wishbone cycle with `adr=0x10`, `we=1`, `sel=0xF`, `dat=0xCAFEBABE`; `b_valid` 2 cycles after the handshake; `bresp=0`.
- **Split write.** W presented 3 cycles before AW, strb 0x3. Expect no Wishbone cycle until AW arrives; then `sel=0x3`; `bresp=OKAY`.
- **Read with wait states.** Read addr 0x20, slave acks after 5 wait cycles with data 0x12345678. Expect `cyc`/`stb` high for 6 cycles, `rdata=0x12345678`, `rresp=0`; `r_valid` held while `r_ready` is low for 4 cycles.
- **Error and simultaneous requests.** Slave asserts `err` on a read, expect `rresp=2'b10`, `rdata=0`. Then issue a write and a read in the same cycle after reset: the write is performed first, then the read.
- **Timeout (with `AXIL2WB_TIMEOUT_EN`).** Slave never acks. Expect `cyc` to drop after `TIMEOUT_CYCLES` and `bresp=SLVERR`. A subsequent stray `ack` produces no extra response.
- **Reset mid-operation.** Assert `rst_ni` low during WB_RD. Expect `wb_cyc_o=0` immediately and no `r_valid` after release. A following read completes normally.

Source files
------------

// File: rtl/axil2wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone classic bridge.
package axil2wb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_WR  = 3'd1,
        WB_RD  = 3'd2,
        B_RESP = 3'd3,
        R_RESP = 3'd4
    } axil2wb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] SEL_ALL     = 4'hF;

endpackage

// File: rtl/AXI_LITE.sv
// Minimal AXI4-Lite bundle (AW, W, B, AR, R) with master and slave views.
interface AXI_LITE #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport Slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport Master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axil2wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master, one single-beat WB cycle per AXI transaction.
// Optional wait-state abort is enabled by defining AXIL2WB_TIMEOUT_EN.
module axil2wb_bridge
    import axil2wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    AXI_LITE.Slave                slave,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("axil2wb_bridge: DATA_WIDTH must be 32 and TIMEOUT_CYCLES within 1..65535");
    end

    axil2wb_state_e        state_q, state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, ar_ready_q, ar_ready_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  last_wr_q, last_wr_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  b_valid_q, b_valid_d, r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
    logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
    logic [3:0]            wb_sel_q, wb_sel_d;
    logic                  wb_we_q, wb_we_d, wb_cyc_q, wb_cyc_d;
    logic                  timeout, term, term_err;

`ifdef AXIL2WB_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Counter runs only while a WB cycle is open, so it is zero on every entry.
    assign timeout = (32'(wait_cnt_q) + 32'd1 == TIMEOUT_CYCLES);
    always_comb wait_cnt_d = (state_q == WB_WR || state_q == WB_RD) ? wait_cnt_q + 16'd1 : 16'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // err beats ack; a timeout is reported like an err.
    assign term     = wb_ack_i || wb_err_i || timeout;
    assign term_err = wb_err_i || (timeout && !wb_ack_i);

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        ar_held_d = ar_held_q;
        aw_addr_d = aw_addr_q;
        ar_addr_d = ar_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        last_wr_d = last_wr_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        b_valid_d = b_valid_q;
        r_valid_d = r_valid_q;
        rdata_d   = rdata_q;
        wb_adr_d  = wb_adr_q;
        wb_dat_d  = wb_dat_q;
        wb_sel_d  = wb_sel_q;
        wb_we_d   = wb_we_q;
        wb_cyc_d  = wb_cyc_q;

        if (slave.aw_valid && aw_ready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = slave.aw_addr;
        end
        if (slave.w_valid && w_ready_q) begin
            w_held_d = 1'b1;
            w_data_d = slave.w_data;
            w_strb_d = slave.w_strb;
        end
        if (slave.ar_valid && ar_ready_q) begin
            ar_held_d = 1'b1;
            ar_addr_d = slave.ar_addr;
        end

        case (state_q)
            IDLE: begin
                if (aw_held_q && w_held_q && (!ar_held_q || !last_wr_q)) begin
                    state_d   = WB_WR;
                    wb_cyc_d  = 1'b1;
                    wb_we_d   = 1'b1;
                    wb_adr_d  = aw_addr_q;
                    wb_dat_d  = w_data_q;
                    wb_sel_d  = w_strb_q;
                    last_wr_d = 1'b1;
                end else if (ar_held_q) begin
                    state_d   = WB_RD;
                    wb_cyc_d  = 1'b1;
                    wb_we_d   = 1'b0;
                    wb_adr_d  = ar_addr_q;
                    wb_sel_d  = SEL_ALL;
                    last_wr_d = 1'b0;
                end
            end
            WB_WR: begin
                if (term) begin
                    state_d   = B_RESP;
                    wb_cyc_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = term_err ? RESP_SLVERR : RESP_OKAY;
                    b_valid_d = 1'b1;
                end
            end
            WB_RD: begin
                if (term) begin
                    state_d   = R_RESP;
                    wb_cyc_d  = 1'b0;
                    ar_held_d = 1'b0;
                    rdata_d   = term_err ? '0 : wb_dat_i;
                    rresp_d   = term_err ? RESP_SLVERR : RESP_OKAY;
                    r_valid_d = 1'b1;
                end
            end
            B_RESP: begin
                if (slave.b_ready) begin
                    b_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            R_RESP: begin
                if (slave.r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered from the next held value, so it tracks !held after reset.
        aw_ready_d = !aw_held_d;
        w_ready_d  = !w_held_d;
        ar_ready_d = !ar_held_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            ar_held_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            ar_ready_q <= 1'b0;
            aw_addr_q  <= '0;
            ar_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            last_wr_q  <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            b_valid_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            rdata_q    <= '0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            wb_sel_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_cyc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            ar_held_q  <= ar_held_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            ar_ready_q <= ar_ready_d;
            aw_addr_q  <= aw_addr_d;
            ar_addr_q  <= ar_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            last_wr_q  <= last_wr_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            b_valid_q  <= b_valid_d;
            r_valid_q  <= r_valid_d;
            rdata_q    <= rdata_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            wb_sel_q   <= wb_sel_d;
            wb_we_q    <= wb_we_d;
            wb_cyc_q   <= wb_cyc_d;
        end
    end

    assign slave.aw_ready = aw_ready_q;
    assign slave.w_ready  = w_ready_q;
    assign slave.ar_ready = ar_ready_q;
    assign slave.b_valid  = b_valid_q;
    assign slave.b_resp   = bresp_q;
    assign slave.r_valid  = r_valid_q;
    assign slave.r_resp   = rresp_q;
    assign slave.r_data   = rdata_q;

    assign wb_adr_o = wb_adr_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_sel_o = wb_sel_q;
    assign wb_we_o  = wb_we_q;
    assign wb_cyc_o = wb_cyc_q;
    assign wb_stb_o = wb_cyc_q;

endmodule

// File: tb/tb_axil2wb_bridge.sv
// Directed, table-driven bench for axil2wb_bridge; the timeout case runs when AXIL2WB_TIMEOUT_EN is defined.
module tb_axil2wb_bridge;

    localparam int TO = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

    axil2wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .slave    (axi),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel),
        .wb_we_o  (wb_we),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack),
        .wb_err_i (wb_err)
    );

    // Behavioural Wishbone slave: terminates after slv_wait wait states.
    int          slv_wait = 0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic        stray_ack = 1'b0;
    int          slv_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n || !wb_cyc) slv_cnt <= 0;
        else                   slv_cnt <= slv_cnt + 1;
    end

    assign wb_ack   = (wb_cyc && wb_stb && slv_cnt == slv_wait && !slv_err) || stray_ack;
    assign wb_err   = wb_cyc && wb_stb && slv_cnt == slv_wait && slv_err;
    assign wb_dat_i = slv_rdata;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wbcap_t;

    wbcap_t caps[$];
    int     mon_cyc = 0;
    int     cyc_count = 0;

    always @(posedge clk) begin
        wbcap_t c;
        cyc_count <= cyc_count + 1;
        if (wb_cyc) mon_cyc <= mon_cyc + 1;
        if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
            c.we  = wb_we;
            c.adr = wb_adr;
            c.dat = wb_dat_o;
            c.sel = wb_sel;
            caps.push_back(c);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or slave read data for reads
        logic [3:0]  strb;
        int          waits;
        bit          err;
        int          rdy_delay;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;   // cycles from last address/data handshake to b/r valid
        int          exp_cyc;   // cycles with cyc high
    } vec_t;

    vec_t vecs[6];

    task automatic send_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int w_lead, output int hs);
        bit aw_pend, w_pend, aw_hs, w_hs;
        int guard;
        axi.aw_addr  = addr;
        axi.w_data   = data;
        axi.w_strb   = strb;
        axi.w_valid  = 1'b1;
        axi.aw_valid = (w_lead == 0);
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        guard   = 0;
        hs      = 0;
        while ((aw_pend || w_pend) && guard < 40) begin
            aw_hs = axi.aw_valid && axi.aw_ready;
            w_hs  = axi.w_valid && axi.w_ready;
            @(negedge clk);
            guard++;
            if (aw_hs) begin aw_pend = 1'b0; axi.aw_valid = 1'b0; hs = cyc_count; end
            if (w_hs)  begin w_pend = 1'b0; axi.w_valid = 1'b0; hs = cyc_count; end
            if (w_lead > 0 && aw_pend) begin
                chk("split_no_wb_cycle", {31'd0, wb_cyc}, 32'd0);
                if (guard == w_lead) axi.aw_valid = 1'b1;
            end
        end
        if (aw_pend || w_pend) chk("write_handshake_done", 32'd0, 32'd1);
    endtask

    task automatic send_read(input logic [31:0] addr, output int hs);
        bit ar_hs;
        int guard;
        axi.ar_addr  = addr;
        axi.ar_valid = 1'b1;
        guard = 0;
        hs    = 0;
        while (axi.ar_valid && guard < 40) begin
            ar_hs = axi.ar_ready;
            @(negedge clk);
            guard++;
            if (ar_hs) begin axi.ar_valid = 1'b0; hs = cyc_count; end
        end
        if (axi.ar_valid) begin
            axi.ar_valid = 1'b0;
            chk("read_handshake_done", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_resp(input bit wr, input int hs, input int rdy_delay, input logic [1:0] exp_resp,
                             input logic [31:0] exp_rdata, input int exp_lat, input string tag);
        int   guard;
        logic vld;
        guard = 0;
        vld = wr ? axi.b_valid : axi.r_valid;
        while (!vld && guard < 300) begin
            @(negedge clk);
            guard++;
            vld = wr ? axi.b_valid : axi.r_valid;
        end
        if (!vld) begin
            chk({tag, "_valid_seen"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(cyc_count - hs), 32'(exp_lat));
        chk({tag, "_resp"}, {30'd0, wr ? axi.b_resp : axi.r_resp}, {30'd0, exp_resp});
        if (!wr) chk({tag, "_rdata"}, axi.r_data, exp_rdata);
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            chk({tag, "_valid_held"}, {31'd0, wr ? axi.b_valid : axi.r_valid}, 32'd1);
        end
        if (wr) axi.b_ready = 1'b1; else axi.r_ready = 1'b1;
        @(negedge clk);
        axi.b_ready = 1'b0;
        axi.r_ready = 1'b0;
        chk({tag, "_valid_dropped"}, {31'd0, wr ? axi.b_valid : axi.r_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int hs;
        caps.delete();
        mon_cyc   = 0;
        slv_wait  = v.waits;
        slv_err   = v.err;
        slv_rdata = v.data;
        if (v.wr) send_write(v.addr, v.data, v.strb, 0, hs);
        else      send_read(v.addr, hs);
        wait_resp(v.wr, hs, v.rdy_delay, v.exp_resp, v.exp_rdata, v.exp_lat, tag);
        chk({tag, "_wb_cycles"}, 32'(caps.size()), 32'd1);
        chk({tag, "_cyc_len"}, 32'(mon_cyc), 32'(v.exp_cyc));
        if (caps.size() > 0) begin
            chk({tag, "_wb_adr"}, caps[0].adr, v.addr);
            chk({tag, "_wb_we"}, {31'd0, caps[0].we}, {31'd0, v.wr});
            chk({tag, "_wb_sel"}, {28'd0, caps[0].sel}, v.wr ? {28'd0, v.strb} : 32'hF);
            if (v.wr) chk({tag, "_wb_dat"}, caps[0].dat, v.data);
        end
        $display("txn %s: %s addr=0x%08h resp=%0d", tag, v.wr ? "WR" : "RD", v.addr, v.exp_resp);
    endtask

    initial begin
        int   hs;
        vec_t v;

        axi.aw_valid = 1'b0; axi.aw_addr = '0;
        axi.w_valid  = 1'b0; axi.w_data  = '0; axi.w_strb = '0;
        axi.ar_valid = 1'b0; axi.ar_addr = '0;
        axi.b_ready  = 1'b0; axi.r_ready = 1'b0;

        //            wr addr          data           strb  wt err rdy resp   rdata          lat cyc
        vecs[0] = '{1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 0, 1'b0, 0, 2'b00, 32'h0,        2,  1};
        vecs[1] = '{1'b0, 32'h20, 32'h12345678, 4'hF, 5, 1'b0, 4, 2'b00, 32'h12345678, 7,  6};
        vecs[2] = '{1'b0, 32'h24, 32'hDEADBEEF, 4'hF, 0, 1'b1, 1, 2'b10, 32'h0,        2,  1};
        vecs[3] = '{1'b1, 32'h30, 32'hA5A50F0F, 4'hC, 2, 1'b1, 0, 2'b10, 32'h0,        4,  3};
        vecs[4] = '{1'b0, 32'h40, 32'h0BADF00D, 4'hF, 1, 1'b0, 0, 2'b00, 32'h0BADF00D, 3,  2};
        vecs[5] = '{1'b1, 32'h44, 32'h11223344, 4'h1, 3, 1'b0, 2, 2'b00, 32'h0,        5,  4};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_aw_ready", {31'd0, axi.aw_ready}, 32'd0);
        chk("rst_w_ready",  {31'd0, axi.w_ready},  32'd0);
        chk("rst_ar_ready", {31'd0, axi.ar_ready}, 32'd0);
        chk("rst_b_valid",  {31'd0, axi.b_valid},  32'd0);
        chk("rst_r_valid",  {31'd0, axi.r_valid},  32'd0);
        chk("rst_wb_cyc",   {31'd0, wb_cyc},       32'd0);
        chk("rst_wb_stb",   {31'd0, wb_stb},       32'd0);
        chk("rst_wb_we",    {31'd0, wb_we},        32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {29'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 32'd7);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Split write: W three cycles ahead of AW
        caps.delete();
        slv_wait = 0; slv_err = 1'b0;
        send_write(32'h50, 32'h0000BEEF, 4'h3, 3, hs);
        wait_resp(1'b1, hs, 0, 2'b00, 32'h0, 2, "split");
        chk("split_wb_cycles", 32'(caps.size()), 32'd1);
        if (caps.size() > 0) chk("split_wb_sel", {28'd0, caps[0].sel}, 32'h3);
        $display("txn split: WR addr=0x00000050 strb=0x3");

        // Reset asserted while a read is waiting on the slave
        slv_wait = 1000; slv_err = 1'b0;
        send_read(32'h58, hs);
        @(negedge clk);
        chk("rstmid_cyc_before", {31'd0, wb_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_cyc_now", {31'd0, wb_cyc}, 32'd0);
        chk("rstmid_stb_now", {31'd0, wb_stb}, 32'd0);
        chk("rstmid_ar_ready", {31'd0, axi.ar_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_r_valid", {30'd0, axi.r_valid, wb_cyc}, 32'd0);
        end
        $display("txn reset_mid_read: aborted");
        v = '{1'b0, 32'h60, 32'h600DCAFE, 4'hF, 0, 1'b0, 0, 2'b00, 32'h600DCAFE, 2, 1};
        run_vec(v, "post_rst");

        // Write and read presented together after reset: write wins
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        caps.delete();
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h77778888;
        axi.aw_addr = 32'h70; axi.w_data = 32'h55AA55AA; axi.w_strb = 4'hF; axi.ar_addr = 32'h74;
        axi.aw_valid = 1'b1; axi.w_valid = 1'b1; axi.ar_valid = 1'b1;
        @(negedge clk);
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
        hs = cyc_count;
        wait_resp(1'b1, hs, 0, 2'b00, 32'h0, 2, "both_wr");
        wait_resp(1'b0, hs, 0, 2'b00, 32'h77778888, 5, "both_rd");
        chk("both_wb_cycles", 32'(caps.size()), 32'd2);
        if (caps.size() == 2) begin
            chk("both_first_we", {31'd0, caps[0].we}, 32'd1);
            chk("both_first_adr", caps[0].adr, 32'h70);
            chk("both_second_we", {31'd0, caps[1].we}, 32'd0);
            chk("both_second_adr", caps[1].adr, 32'h74);
        end
        $display("txn simultaneous: WR 0x70 then RD 0x74");

`ifdef AXIL2WB_TIMEOUT_EN
        // Slave never answers; bridge aborts after TO cycles
        caps.delete();
        mon_cyc  = 0;
        slv_wait = 100000; slv_err = 1'b0;
        send_write(32'h80, 32'h13579BDF, 4'hF, 0, hs);
        wait_resp(1'b1, hs, 0, 2'b10, 32'h0, TO + 1, "timeout");
        chk("timeout_cyc_len", 32'(mon_cyc), 32'(TO));
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("timeout_no_extra_resp", {30'd0, axi.b_valid, axi.r_valid}, 32'd0);
        end
        $display("txn timeout: WR addr=0x00000080 aborted");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
